systolic_skew_feeder: RTL
=========================

Name: systolic_skew_feeder

Overview:
Upstream stage of the output-stationary systolic array. Accepts one A column-vector (ROWS words) and one B row-vector (COLS words) per beat over valid/ready. It applies the diagonal skew the array needs: row r delayed r cycles, column c delayed c cycles. It then drives left_in_bus and top_in_bus, flushes the pipeline with zeros, and sequences ctl_stat_bit_in for the result drain.

Parameters:
ROWS, 32, array rows (lanes on left_in_bus)
COLS, 32, array columns (lanes on top_in_bus)
WORD_SIZE, 16, bits per operand word
K_WIDTH, 16, width of the reduction-length field

Ports:
clk  input  1  clock
rst  input  1  reset, asynchronous, active-low
start  input  1  one-cycle pulse; begins a tile; sampled only in IDLE
k_len  input  K_WIDTH  number of A/B beats in the tile; sampled with start
a_valid  input  1  A beat available
a_ready  output  1  A beat accepted when a_valid&&a_ready
a_data  input  ROWS*WORD_SIZE  lane r = bits [(r+1)*WORD_SIZE-1 -: WORD_SIZE]
b_valid  input  1  B beat available
b_ready  output  1  B beat accepted when b_valid&&b_ready
b_data  input  COLS*WORD_SIZE  lane c packed as a_data
left_in_bus  output  ROWS*WORD_SIZE  skewed A to array
top_in_bus  output  COLS*WORD_SIZE  skewed B to array
ctl_stat_bit_in  output  1  drain-mode select to array
busy  output  1  high in any state except IDLE
done  output  1  one-cycle pulse at tile completion

Behaviour:
- Reset (rst low, async): state IDLE; all skew registers, left_in_bus, top_in_bus, ctl_stat_bit_in, done, beat and flush counters cleared to 0. a_ready/b_ready are 0.
- States: IDLE, FEED, FLUSH, DRAIN, DONE.
- IDLE: on start with k_len!=0, latch k_len and go to FEED. On start with k_len==0, go to DONE with no beats accepted and no drain. start in any other state is ignored.
- FEED:
  - a_ready = b_valid; b_ready = a_valid. A and B are always consumed together.
  - A joint beat is accepted when a_valid&&b_valid. Each accepted beat increments beat_cnt.
  - Each FEED cycle, skew stage 0 of every lane loads the accepted data. If no beat is accepted, it loads zeros (a bubble). Zero bubbles keep A/B alignment and contribute 0 to accumulators.
  - When the k_len-th beat is accepted, go to FLUSH the next cycle.
- Skew: lane r of left_in_bus is registered through r+1 stages. The A word accepted at cycle t appears on lane r at cycle t+1+r. B lane c behaves the same with c+1 stages. Lane 0 therefore has exactly 1 cycle latency.
- FLUSH: a_ready=b_ready=0. Zeros enter stage 0 for ROWS+COLS-1 cycles, counted by flush_cnt, then go to DRAIN.
- DRAIN: ctl_stat_bit_in=1 for exactly ROWS cycles, inputs stay zero, then go to DONE. ctl_stat_bit_in is 0 in every other state.
- DONE: done=1 for one cycle, busy still 1, then IDLE.
- Counters are K_WIDTH bits wide, with no wrap within a tile: k_len max is 2^K_WIDTH-1.
- Reset asserted mid-tile: immediate return to IDLE with all pipeline contents zeroed. Partial beats are lost; upstream must re-issue.
- Outputs are fully registered; there is no combinational path from a_data/b_data to the array buses.

Test Plan:
1. ROWS=COLS=2, k_len=2, A beats {lane0=1,lane1=2},{3,4} and B beats {5,6},{7,8}, valid every cycle. Required response:
   - left lane0 shows 1,3 at cycles t+1,t+2; left lane1 shows 2,4 at t+2,t+3.
   - top lanes match with 5,7 and 6,8.
   - FLUSH lasts 3 cycles, ctl_stat_bit_in is high 2 cycles, then done pulses once.
2. Bubble: same data, b_valid low for one cycle between beats.
   - a_ready must be 0 that cycle and no A beat is consumed.
   - A zero word is inserted on both buses at the same skew position.
   - beat_cnt ends at 2.
3. k_len=0 start: no a_ready/b_ready asserted, ctl_stat_bit_in never 1, done pulses 1 cycle after start.
4. Assert rst low mid-FEED, asynchronously between edges. Required response:
   - Outputs go to 0 immediately, busy=0.
   - A new start with k_len=1 then completes normally.
5. start pulsed during FLUSH and DRAIN is ignored: exactly one done, with timing unchanged.
6. Default ROWS=COLS=32: lane 31 output lags lane 0 by exactly 31 cycles for an identical beat value (e.g. 16'hA5A5).

Source files
------------

// File: rtl/systolic_skew_feeder.sv
// Skews A/B beats onto the systolic array (lane r/c delayed r+1/c+1 cycles), then flushes zeros and sequences drain mode.
// Fully registered buses; A and B are only taken together, so each ready mirrors the other side's valid during FEED.
module systolic_skew_feeder #(
  parameter int ROWS      = 32,
  parameter int COLS      = 32,
  parameter int WORD_SIZE = 16,
  parameter int K_WIDTH   = 16
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      start,
  input  logic [K_WIDTH-1:0]        k_len,
  input  logic                      a_valid,
  output logic                      a_ready,
  input  logic [ROWS*WORD_SIZE-1:0] a_data,
  input  logic                      b_valid,
  output logic                      b_ready,
  input  logic [COLS*WORD_SIZE-1:0] b_data,
  output logic [ROWS*WORD_SIZE-1:0] left_in_bus,
  output logic [COLS*WORD_SIZE-1:0] top_in_bus,
  output logic                      ctl_stat_bit_in,
  output logic                      busy,
  output logic                      done
);

  typedef enum logic [2:0] {IDLE, FEED, FLUSH, DRAIN, DONE} state_t;

  localparam logic [K_WIDTH-1:0] FLUSH_LAST = K_WIDTH'(ROWS + COLS - 2);
  localparam logic [K_WIDTH-1:0] DRAIN_LAST = K_WIDTH'(ROWS - 1);

  state_t             state, state_nxt;
  logic [K_WIDTH-1:0] k_lat;
  logic [K_WIDTH-1:0] beat_cnt;
  logic [K_WIDTH-1:0] flush_cnt;
  logic               beat_acc;

  assign beat_acc = (state == FEED) && a_valid && b_valid;
  assign busy     = (state != IDLE);

  always_comb begin
    state_nxt = state;
    a_ready   = 1'b0;
    b_ready   = 1'b0;
    case (state)
      IDLE: begin
        if (start) state_nxt = (k_len == '0) ? DONE : FEED;
      end
      FEED: begin
        a_ready = b_valid;
        b_ready = a_valid;
        if (beat_acc && (beat_cnt == k_lat - K_WIDTH'(1))) state_nxt = FLUSH;
      end
      FLUSH: begin
        if (flush_cnt == FLUSH_LAST) state_nxt = DRAIN;
      end
      DRAIN: begin
        if (flush_cnt == DRAIN_LAST) state_nxt = DONE;
      end
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // flush_cnt is shared: it times both the zero flush and the drain window.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state           <= IDLE;
      k_lat           <= '0;
      beat_cnt        <= '0;
      flush_cnt       <= '0;
      ctl_stat_bit_in <= 1'b0;
      done            <= 1'b0;
    end else begin
      state           <= state_nxt;
      ctl_stat_bit_in <= (state_nxt == DRAIN);
      done            <= (state_nxt == DONE);
      if (state == IDLE && start) begin
        k_lat    <= k_len;
        beat_cnt <= '0;
      end else if (beat_acc) begin
        beat_cnt <= beat_cnt + K_WIDTH'(1);
      end
      if (state != state_nxt)
        flush_cnt <= '0;
      else if (state == FLUSH || state == DRAIN)
        flush_cnt <= flush_cnt + K_WIDTH'(1);
    end
  end

  // Stage 0 takes the accepted word or a zero bubble; lane r then ages through r more stages.
  for (genvar r = 0; r < ROWS; r++) begin : g_a_lane
    logic [WORD_SIZE-1:0] sr [0:r];
    always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
        sr <= '{default: '0};
      end else begin
        sr[0] <= beat_acc ? a_data[r*WORD_SIZE +: WORD_SIZE] : '0;
        for (int i = 1; i <= r; i++) sr[i] <= sr[i-1];
      end
    end
    assign left_in_bus[r*WORD_SIZE +: WORD_SIZE] = sr[r];
  end

  for (genvar c = 0; c < COLS; c++) begin : g_b_lane
    logic [WORD_SIZE-1:0] sr [0:c];
    always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
        sr <= '{default: '0};
      end else begin
        sr[0] <= beat_acc ? b_data[c*WORD_SIZE +: WORD_SIZE] : '0;
        for (int i = 1; i <= c; i++) sr[i] <= sr[i-1];
      end
    end
    assign top_in_bus[c*WORD_SIZE +: WORD_SIZE] = sr[c];
  end

endmodule
